// File: rtl/fifo_flow_ctrl_pkg.sv
// Shared definitions for the lane buffer: default widths, hysteresis state
// encoding and reset threshold helpers, reused by the lane FSM and 4-lane wrapper.
package fifo_flow_ctrl_pkg;

  localparam int DEF_DATA_WIDTH = 6;
  localparam int DEF_ADDR_WIDTH = 3;

  typedef enum logic {
    NORMAL = 1'b0,
    PAUSED = 1'b1
  } flow_state_t;

  localparam int RST_LO_THRESH = 2;

  // Reset pause threshold sits two words below full.
  function automatic int rst_hi_thresh(input int addr_width);
    return (1 << addr_width) - 2;
  endfunction

endpackage

// File: rtl/fifo_flow_ctrl_mem.sv
// Dual-port register file: one write port, one synchronous read port.
// The array is not reset; only the read register is.
module fifo_flow_ctrl_mem #(
  parameter int DW = 6,
  parameter int AW = 3
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [DW-1:0] i_wr_data,
  input  logic          i_rd_en,
  input  logic [AW-1:0] i_rd_addr,
  output logic [DW-1:0] o_rd_data
);

  logic [DW-1:0] r_mem [(1<<AW)];
  logic [DW-1:0] r_rd_data;

  // Write port
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Read register holds its value when no pop is accepted
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_data <= '0;
    end else if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end else begin
      r_rd_data <= r_rd_data;
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/fifo_flow_ctrl.sv
// One lane of the data buffer: synchronous FIFO with sticky error and a
// pause/continue hysteresis FSM driven by thresholds latched during Init.
module fifo_flow_ctrl
  import fifo_flow_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  CLK,
  input  logic                  sReset,
  input  logic                  sInit,
  input  logic [ADDR_WIDTH:0]   umbral_alto,
  input  logic [ADDR_WIDTH:0]   umbral_bajo,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  empty,
  output logic                  full,
  output logic                  pause,
  output logic                  continue_o,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   count
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(1 << ADDR_WIDTH);
  localparam logic [CW-1:0] RST_HI_C = CW'(rst_hi_thresh(ADDR_WIDTH));
  localparam logic [CW-1:0] RST_LO_C = CW'(RST_LO_THRESH);

  logic [ADDR_WIDTH-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]         r_count, r_hi, r_lo;
  logic                  r_error, r_valid, r_continue;
  flow_state_t           r_state;

  logic [CW-1:0] w_next_count, w_alto_sat, w_bajo_sat, w_hi_ld, w_lo_ld;
  logic          w_push, w_pop, w_err;
  logic          w_continue_nx;
  flow_state_t   w_state_nx;

  assign empty = (r_count == '0);
  assign full  = (r_count == DEPTH_C);

  // Pop needs data; push needs room, or a same-edge pop freeing a slot.
  assign w_pop  = rd_en & ~sInit & ~empty;
  assign w_push = wr_en & ~sInit & (~full | w_pop);
  assign w_err  = ~sInit & ((rd_en & empty) | (wr_en & ~w_push));

  // Next occupancy
  always_comb begin
    w_next_count = r_count;
    case ({w_push, w_pop})
      2'b10:   w_next_count = r_count + CW'(1);
      2'b01:   w_next_count = r_count - CW'(1);
      default: w_next_count = r_count;
    endcase
  end

  // Sanitised threshold values to latch during Init
  always_comb begin
    w_alto_sat = (umbral_alto > DEPTH_C) ? DEPTH_C : umbral_alto;
    w_bajo_sat = (umbral_bajo > DEPTH_C) ? DEPTH_C : umbral_bajo;
    w_hi_ld    = w_alto_sat;
    w_lo_ld    = w_bajo_sat;
    if (w_alto_sat == '0) begin
      w_hi_ld = CW'(1);
      w_lo_ld = '0;
    end else if (w_bajo_sat >= w_alto_sat) begin
      w_lo_ld = w_alto_sat - CW'(1);
    end else begin
      w_lo_ld = w_bajo_sat;
    end
  end

  // Hysteresis next state; the pause condition wins when both hold
  always_comb begin
    w_state_nx    = r_state;
    w_continue_nx = 1'b0;
    case (r_state)
      NORMAL: begin
        if (w_next_count >= r_hi) begin
          w_state_nx = PAUSED;
        end else begin
          w_state_nx = NORMAL;
        end
      end
      PAUSED: begin
        if ((w_next_count <= r_lo) && (w_next_count < r_hi)) begin
          w_state_nx    = NORMAL;
          w_continue_nx = 1'b1;
        end else begin
          w_state_nx = PAUSED;
        end
      end
      default: w_state_nx = NORMAL;
    endcase
  end

  // Pointers, occupancy, flags and FSM state
  always_ff @(posedge CLK or negedge sReset) begin
    if (!sReset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_error    <= 1'b0;
      r_valid    <= 1'b0;
      r_continue <= 1'b0;
      r_state    <= NORMAL;
    end else begin
      r_wr_ptr   <= w_push ? r_wr_ptr + ADDR_WIDTH'(1) : r_wr_ptr;
      r_rd_ptr   <= w_pop  ? r_rd_ptr + ADDR_WIDTH'(1) : r_rd_ptr;
      r_count    <= w_next_count;
      r_error    <= r_error | w_err;
      r_valid    <= w_pop;
      r_continue <= w_continue_nx;
      r_state    <= w_state_nx;
    end
  end

  // Threshold registers
  always_ff @(posedge CLK or negedge sReset) begin
    if (!sReset) begin
      r_hi <= RST_HI_C;
      r_lo <= RST_LO_C;
    end else if (sInit) begin
      r_hi <= w_hi_ld;
      r_lo <= w_lo_ld;
    end else begin
      r_hi <= r_hi;
      r_lo <= r_lo;
    end
  end

  fifo_flow_ctrl_mem #(
    .DW(DATA_WIDTH),
    .AW(ADDR_WIDTH)
  ) u_mem (
    .i_clk     (CLK),
    .i_rst_n   (sReset),
    .i_wr_en   (w_push),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (data_in),
    .i_rd_en   (w_pop),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (data_out)
  );

  assign valid_out  = r_valid;
  assign pause      = (r_state == PAUSED);
  assign continue_o = r_continue;
  assign error      = r_error;
  assign count      = r_count;

endmodule

// File: tb/tb_fifo_flow_ctrl.sv
// Directed plus randomized bench for fifo_flow_ctrl against a queue-based
// reference model of the lane buffer and its pause/continue rules.
module tb_fifo_flow_ctrl;

  logic       CLK = 1'b0;
  logic       sReset = 1'b0;
  logic       sInit = 1'b0;
  logic [3:0] umbral_alto = 4'd0, umbral_bajo = 4'd0;
  logic       wr_en = 1'b0, rd_en = 1'b0;
  logic [5:0] data_in = 6'd0;
  logic [5:0] data_out;
  logic       valid_out, empty, full, pause, continue_o, error;
  logic [3:0] count;

  int total = 0;
  int bad = 0;

  // Reference model state
  logic [5:0] q[$];
  logic [5:0] m_last;
  int         m_hi, m_lo;
  bit         m_paused, m_cont, m_err, m_valid;

  fifo_flow_ctrl dut (
    .CLK(CLK), .sReset(sReset), .sInit(sInit),
    .umbral_alto(umbral_alto), .umbral_bajo(umbral_bajo),
    .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .data_out(data_out), .valid_out(valid_out), .empty(empty), .full(full),
    .pause(pause), .continue_o(continue_o), .error(error), .count(count)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ph);
    chk({ph, ".count"}, 32'(count), 32'(q.size()));
    chk({ph, ".empty"}, 32'(empty), 32'(q.size() == 0));
    chk({ph, ".full"}, 32'(full), 32'(q.size() == 8));
    chk({ph, ".pause"}, 32'(pause), 32'(m_paused));
    chk({ph, ".continue"}, 32'(continue_o), 32'(m_cont));
    chk({ph, ".error"}, 32'(error), 32'(m_err));
    chk({ph, ".valid"}, 32'(valid_out), 32'(m_valid));
    chk({ph, ".data"}, 32'(data_out), 32'(m_last));
  endtask

  task automatic model_reset();
    q.delete();
    m_last = 6'd0; m_hi = 6; m_lo = 2;
    m_paused = 0; m_cont = 0; m_err = 0; m_valid = 0;
  endtask

  // One rising edge of the lane, in terms of occupancy and queue order
  task automatic model_edge();
    bit pop_ok, push_ok;
    int a, b, n;
    pop_ok = 0; push_ok = 0;
    if (!sInit) begin
      pop_ok  = rd_en && (q.size() > 0);
      push_ok = wr_en && (q.size() < 8 || pop_ok);
      if ((rd_en && q.size() == 0) || (wr_en && !push_ok)) m_err = 1;
    end
    m_valid = pop_ok;
    if (pop_ok) m_last = q.pop_front();
    if (push_ok) q.push_back(data_in);
    n = q.size();
    m_cont = 0;
    if (!m_paused) begin
      if (n >= m_hi) m_paused = 1;
    end else if (n <= m_lo && n < m_hi) begin
      m_paused = 0;
      m_cont = 1;
    end
    if (sInit) begin
      a = (umbral_alto > 8) ? 8 : int'(umbral_alto);
      b = (umbral_bajo > 8) ? 8 : int'(umbral_bajo);
      if (a == 0) begin m_hi = 1; m_lo = 0; end
      else begin m_hi = a; m_lo = (b >= a) ? a - 1 : b; end
    end
  endtask

  task automatic step(input string ph, input logic ini, input logic [3:0] ah, input logic [3:0] al,
                      input logic w, input logic [5:0] d, input logic r);
    sInit = ini; umbral_alto = ah; umbral_bajo = al;
    wr_en = w; data_in = d; rd_en = r;
    @(posedge CLK);
    model_edge();
    #1;
    check_all(ph);
  endtask

  task automatic async_reset(input string ph);
    @(posedge CLK);
    #3;
    sReset = 1'b0;
    model_reset();
    #1;
    check_all(ph);
    @(negedge CLK);
    sReset = 1'b1;
    sInit = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
  endtask

  initial begin
    model_reset();
    #12;
    check_all("reset");
    #2;
    sReset = 1'b1;

    step("init", 1'b1, 4'd6, 4'd2, 1'b0, 6'd0, 1'b0);
    for (int i = 1; i <= 8; i++) step("fill", 1'b0, 4'd0, 4'd0, 1'b1, 6'(i), 1'b0);
    step("overflow", 1'b0, 4'd0, 4'd0, 1'b1, 6'd9, 1'b0);
    for (int i = 0; i < 8; i++) step("drain", 1'b0, 4'd0, 4'd0, 1'b0, 6'd0, 1'b1);

    for (int i = 0; i < 8; i++) step("refill", 1'b0, 4'd0, 4'd0, 1'b1, 6'(20 + i), 1'b0);
    for (int i = 0; i < 4; i++) step("simul_full", 1'b0, 4'd0, 4'd0, 1'b1, 6'(40 + i), 1'b1);
    for (int i = 0; i < 8; i++) step("drain2", 1'b0, 4'd0, 4'd0, 1'b0, 6'd0, 1'b1);
    step("simul_empty", 1'b0, 4'd0, 4'd0, 1'b1, 6'd55, 1'b1);
    step("pop_last", 1'b0, 4'd0, 4'd0, 1'b0, 6'd0, 1'b1);

    async_reset("rst1");
    step("bad_thr", 1'b1, 4'd3, 4'd5, 1'b1, 6'd7, 1'b0);
    step("init_block", 1'b1, 4'd3, 4'd5, 1'b1, 6'd8, 1'b1);
    for (int i = 0; i < 5; i++) step("fill5", 1'b0, 4'd0, 4'd0, 1'b1, 6'(i + 1), 1'b0);
    for (int i = 0; i < 3; i++) step("lo2", 1'b0, 4'd0, 4'd0, 1'b0, 6'd0, 1'b1);
    for (int i = 0; i < 3; i++) step("refill5", 1'b0, 4'd0, 4'd0, 1'b1, 6'(i + 9), 1'b0);
    async_reset("rst_mid");

    step("zero_thr", 1'b1, 4'd0, 4'd0, 1'b0, 6'd0, 1'b0);
    step("z_push", 1'b0, 4'd0, 4'd0, 1'b1, 6'd33, 1'b0);
    step("z_pop", 1'b0, 4'd0, 4'd0, 1'b0, 6'd0, 1'b1);
    step("sat_thr", 1'b1, 4'd15, 4'd12, 1'b0, 6'd0, 1'b0);

    for (int i = 0; i < 400; i++) begin
      step("rand", ($urandom_range(19) == 0), 4'($urandom_range(15)), 4'($urandom_range(15)),
           1'($urandom_range(1)), 6'($urandom), 1'($urandom_range(1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
